jpeg_rle_encoder_14bit: RTL
===========================

# jpeg_rle_encoder_14bit

Run-length encoder for the JPEG datapath. It consumes one block of quantized 8-bit coefficients in zig-zag order and emits 14-bit symbols {run[5:0], value[7:0]}. `run` is the count of zero coefficients that precede `value`. Every block ends with the end-of-block (EOB) marker 14'h3FFF. Its output feeds the 14-bit symbol decoder directly: that decoder expands each symbol into (run+1) bytes and treats all-ones as EOB and all-zeros as a null symbol, so this encoder must never emit 14'h0000 or a data symbol equal to 14'h3FFF.

## Interface
- BLOCK_LEN, 64, coefficients per block; legal range 2..64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  coefficient available
- in_ready  out  1  encoder accepts a coefficient this cycle
- in_data  in  8  quantized coefficient (any 8-bit pattern)
- out_valid  out  1  symbol held on out_sym
- out_ready  in  1  downstream takes the symbol this cycle
- out_sym  out  14  {run, value}, or 14'h3FFF for EOB
- out_last  out  1  high together with the EOB symbol

## Operation
- Transfer rules:
  - An input transfer occurs on in_valid && in_ready.
  - An output transfer occurs on out_valid && out_ready.
- Counters:
  - idx: 6 bits; counts the position within the block (0..BLOCK_LEN-1).
  - run: 6 bits; counts consecutive zeros since the last emitted symbol.
- States:
  - ACCEPT: taking coefficients.
  - ESC: second half of the escape pair is pending.
  - EOB: EOB marker is pending.
- ACCEPT, accepted coefficient c at index idx:
  - c==0 and idx<BLOCK_LEN-1: run++, no symbol.
  - c!=0 and idx<BLOCK_LEN-1: load {run,c}; run←0.
  - idx==BLOCK_LEN-1 and c==0: load EOB; run, idx←0.
  - idx==BLOCK_LEN-1, c!=0, and {run,c}!=14'h3FFF: load {run,c}; go to EOB.
  - idx==BLOCK_LEN-1, run==63, c==8'hFF (escape case): load 14'h3E00 (63 zeros); go to ESC.
- ESC: after 14'h3E00 transfers, load 14'h00FF; go to EOB.
- EOB: after the pending symbol transfers, load 14'h3FFF with out_last=1; go to ACCEPT; idx, run←0.
- in_ready = rst_n && state==ACCEPT && (!out_valid || out_ready).
- Output register:
  - Loads whenever a symbol is produced.
  - Holds out_sym and out_last while out_valid && !out_ready.
  - Clears out_valid on transfer with no new load.
- A data symbol with value 0 exists only as the escape half 14'h3E00; 14'h0000 is never emitted.
- Reset values: out_valid=0, out_sym=14'h0000, out_last=0, state=ACCEPT, idx=0, run=0. in_ready=0 while rst_n=0.
- Reset mid-block discards the partial block and any pending symbol. The first coefficient after release is index 0.

## Timing
- Latency:
  - Nonzero coefficient accepted in cycle N → its symbol is valid in cycle N+1.
  - Zero coefficient → no output.
- Throughput:
  - 1 coefficient/cycle with out_ready held high.
  - The block-end expansion stalls input 1 cycle, or 2 cycles in the escape case.
- Backpressure: in_ready falls in the same cycle out_valid && !out_ready, so no symbol is ever dropped or duplicated.
- Simultaneous events:
  - Output transfer plus new load in the same cycle: the new symbol replaces the old one in that edge.
  - Back-to-back blocks: index 0 of the next block may be accepted in the cycle the EOB transfers.
- Symbols per block: 1 (all zeros) to BLOCK_LEN+1; the escape case yields exactly 3.

## Structure
- Package jpeg_rle_pkg holds:
  - SYM_W=14, RUN_W=6, VAL_W=8.
  - EOB_SYM=14'h3FFF, ESC_ZERO_SYM=14'h3E00.
  - Encoder state enum (ACCEPT, ESC, EOB).
- Shared with the decoder so both ends use identical constants.
- Single flat module. The output register is small enough that no sub-module is warranted.

## Test plan
- Block {0x12, 63×0x00}, out_ready=1 → 14'h0012, then 14'h3FFF with out_last=1. in_ready stays 1 throughout.
- Zeros at indices 0–2, 0x05 at 3, 0x80 at 10, rest zero → 14'h0305, 14'h0680, 14'h3FFF.
- All 64 zeros → exactly one symbol, 14'h3FFF.
- 63 zeros then 0xFF → 14'h3E00, 14'h00FF, 14'h3FFF; in_ready low for 2 cycles after acceptance.
- 64×0x01 with out_ready random at 50% → 64×14'h0001 then EOB. Checker confirms out_sym stable during stalls and no loss or duplication.
- Assert rst_n low after 10 coefficients while a symbol is pending → out_valid=0 immediately. The next full block encodes from index 0 with a correct EOB.

Source files
------------

// File: rtl/jpeg_rle_pkg.sv
// Constants and state encoding shared by the JPEG run-length encoder and the
// 14-bit symbol decoder, so both ends agree on symbol layout and markers.
package jpeg_rle_pkg;

   localparam int SYM_W = 14;
   localparam int RUN_W = 6;
   localparam int VAL_W = 8;

   localparam logic [SYM_W-1:0] EOB_SYM      = 14'h3FFF;
   localparam logic [SYM_W-1:0] ESC_ZERO_SYM = 14'h3E00;
   // Second half of the escape pair: no preceding zeros, value 0xFF.
   localparam logic [SYM_W-1:0] ESC_TAIL_SYM = 14'h00FF;

   typedef enum logic [1:0] {
      ACCEPT,
      ESC,
      EOB
   } enc_state_e;

endpackage

// File: rtl/jpeg_rle_encoder_14bit.sv
// Run-length encoder: one block of quantized coefficients in, {run, value}
// symbols out, terminated by an EOB marker, with a registered output stage.
module jpeg_rle_encoder_14bit
   import jpeg_rle_pkg::*;
#(
   parameter int BLOCK_LEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [VAL_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SYM_W-1:0]  out_sym,
   output logic              out_last
);

   localparam logic [RUN_W-1:0] LAST_IDX = RUN_W'(BLOCK_LEN - 1);

   enc_state_e       state, state_nxt;
   logic [RUN_W-1:0] idx, idx_nxt;
   logic [RUN_W-1:0] run, run_nxt;
   logic             valid_nxt;
   logic [SYM_W-1:0] sym_nxt;
   logic             last_nxt;
   logic             accept;
   logic             out_xfer;

   assign out_xfer = out_valid && out_ready;
   assign in_ready = rst_n && (state == ACCEPT) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt = state;
      idx_nxt   = idx;
      run_nxt   = run;
      valid_nxt = out_valid && !out_ready;
      sym_nxt   = out_sym;
      last_nxt  = out_last;

      unique case (state)
         ACCEPT: begin
            if (accept) begin
               if (idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  run_nxt   = '0;
                  valid_nxt = 1'b1;
                  last_nxt  = 1'b0;
                  if (in_data == '0) begin
                     sym_nxt  = EOB_SYM;
                     last_nxt = 1'b1;
                  end else if (run == '1 && in_data == '1) begin
                     // {63, 0xFF} would alias the EOB marker; split it in two.
                     sym_nxt   = ESC_ZERO_SYM;
                     state_nxt = ESC;
                  end else begin
                     sym_nxt   = {run, in_data};
                     state_nxt = EOB;
                  end
               end else begin
                  idx_nxt = idx + RUN_W'(1);
                  if (in_data == '0) begin
                     run_nxt = run + RUN_W'(1);
                  end else begin
                     run_nxt   = '0;
                     valid_nxt = 1'b1;
                     sym_nxt   = {run, in_data};
                     last_nxt  = 1'b0;
                  end
               end
            end
         end
         ESC: begin
            if (out_xfer) begin
               valid_nxt = 1'b1;
               sym_nxt   = ESC_TAIL_SYM;
               last_nxt  = 1'b0;
               state_nxt = EOB;
            end
         end
         EOB: begin
            if (out_xfer) begin
               valid_nxt = 1'b1;
               sym_nxt   = EOB_SYM;
               last_nxt  = 1'b1;
               state_nxt = ACCEPT;
               idx_nxt   = '0;
               run_nxt   = '0;
            end
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCEPT;
         idx       <= '0;
         run       <= '0;
         out_valid <= 1'b0;
         out_sym   <= '0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         run       <= run_nxt;
         out_valid <= valid_nxt;
         out_sym   <= sym_nxt;
         out_last  <= last_nxt;
      end
   end

endmodule
